output_stage: RTL and testbench

Third pipeline stage of the SHAKE core. It takes one rate block per permutation from the permute stage, holds it in a single-entry output buffer, and drains it onto the external output as W-bit words under valid/ready flow control. It owns the `output_buffer_available` flag that throttles the permute stage, and it flags the final word of the whole hash output.

---
 rtl/output_stage.sv | 115 +++++++++++
 tb/tb_output_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/output_stage.sv
// Output stage of the SHAKE core. It holds one rate block from the permute stage
// in a single-entry buffer and drains it as W-bit words under valid/ready.
// It also owns the output_buffer_available flag and marks the final hash word.
module output_stage #(
  parameter int W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1343:0] rate_input,
  input  logic [1:0]    operation_mode_in,
  input  logic [31:0]   output_size_in,
  input  logic          output_buffer_we,
  input  logic          last_output_block_wr,
  input  logic          output_buffer_available_clr,
  output logic          output_buffer_available,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last
);

  localparam int RATE_SHAKE128 = 1344;
  localparam int RATE_SHAKE256 = 1088;
  localparam int LOG_W         = $clog2(W);
  localparam int CNT_W         = $clog2(RATE_SHAKE128 / W + 1);

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Words to emit for one block: ceil(size/W) capped at the rate in words.
  // The 33-bit sum keeps size = 2^32-1 from wrapping.
  function automatic logic [CNT_W-1:0] block_words(input logic [31:0] size,
                                                   input logic        shake256);
    logic [32:0] need;
    logic [32:0] cap;
    need = ({1'b0, size} + 33'(W - 1)) >> LOG_W;
    cap  = shake256 ? 33'(RATE_SHAKE256 / W) : 33'(RATE_SHAKE128 / W);
    if (need > cap) need = cap;
    return need[CNT_W-1:0];
  endfunction

  state_t                state;
  state_t                state_nxt;
  logic [RATE_SHAKE128-1:0] shreg;
  logic [CNT_W-1:0]      words_left;
  logic                  last_q;
  logic                  avail_q;
  logic                  drop_q;

  logic load;
  logic drop;
  logic hs;
  logic final_hs;

  // Mode bit 1 carries no meaning for this stage.
  logic unused_mode;
  assign unused_mode = operation_mode_in[1];

  // A write is honoured only while empty; a zero-size write is dropped.
  assign load     = (state == EMPTY) && output_buffer_we && (output_size_in != 32'd0);
  assign drop     = (state == EMPTY) && output_buffer_we && (output_size_in == 32'd0);
  assign hs       = dout_valid && dout_ready;
  assign final_hs = hs && (words_left == CNT_W'(1));

  assign dout_valid              = (state == DRAIN);
  assign dout                    = dout_valid ? shreg[W-1:0] : '0;
  assign dout_last               = last_q && (words_left == CNT_W'(1)) && dout_valid;
  assign output_buffer_available = avail_q;

  // Next-state logic: fill on write, empty on the last handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load)     state_nxt = DRAIN;
      DRAIN:   if (final_hs) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Control registers: word counter, last-block marker and available flag.
  // A dropped zero-size block re-arms the flag one cycle after its write.
  always_ff @(posedge clk) begin
    if (rst) begin
      words_left <= '0;
      last_q     <= 1'b0;
      avail_q    <= 1'b1;
      drop_q     <= 1'b0;
    end else begin
      drop_q <= drop;
      if (load) begin
        words_left <= block_words(output_size_in, operation_mode_in[0]);
        last_q     <= last_output_block_wr;
      end else if (hs) begin
        words_left <= words_left - CNT_W'(1);
      end
      if (output_buffer_available_clr) avail_q <= 1'b0;
      else if (final_hs || drop_q)     avail_q <= 1'b1;
    end
  end

  // Data shift register: load the block, shift one word out per handshake.
  always_ff @(posedge clk) begin
    if (load)    shreg <= rate_input;
    else if (hs) shreg <= shreg >> W;
  end

endmodule

// File: tb/tb_output_stage.sv
// Scoreboard bench for output_stage (W = 64): stimulus pushes the expected words,
// a monitor pops and compares on every handshake.
module tb_output_stage;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1343:0] rate_input = '0;
  logic [1:0]    operation_mode_in = 2'd0;
  logic [31:0]   output_size_in = 32'd0;
  logic          output_buffer_we = 1'b0;
  logic          last_output_block_wr = 1'b0;
  logic          output_buffer_available_clr = 1'b0;
  logic          output_buffer_available;
  logic [63:0]   dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          dout_last;

  typedef struct {
    logic [63:0] d;
    logic        last;
    logic        blk_end;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   pop_cnt = 0;
  int   ready_mode = 1;  // 0 low, 1 high, 2 random

  logic        chk_empty = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_rst = 1'b0;
  logic [63:0] prev_dout = '0;
  logic        prev_last = 1'b0;

  output_stage #(.W(64)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .rate_input                  (rate_input),
    .operation_mode_in           (operation_mode_in),
    .output_size_in              (output_size_in),
    .output_buffer_we            (output_buffer_we),
    .last_output_block_wr        (last_output_block_wr),
    .output_buffer_available_clr (output_buffer_available_clr),
    .output_buffer_available     (output_buffer_available),
    .dout                        (dout),
    .dout_valid                  (dout_valid),
    .dout_ready                  (dout_ready),
    .dout_last                   (dout_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [1343:0] rand_block();
    logic [1343:0] b;
    for (int i = 0; i < 42; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  // Single driver of dout_ready, applied after the other stimulus settles.
  always @(posedge clk) begin
    #2;
    if (ready_mode == 0)      dout_ready = 1'b0;
    else if (ready_mode == 1) dout_ready = 1'b1;
    else                      dout_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: compare handshaked words, stall stability and flag behaviour.
  always @(negedge clk) begin
    exp_t e;
    if (chk_empty) begin
      chk_empty = 1'b0;
      chk("flag_after_drain", 64'(output_buffer_available), 64'd1);
      chk("valid_after_drain", 64'(dout_valid), 64'd0);
    end
    if (prev_stall && !prev_rst) begin
      chk("valid_held_in_stall", 64'(dout_valid), 64'd1);
      if (dout_valid) begin
        chk("dout_stable", dout, prev_dout);
        chk("last_stable", 64'(dout_last), 64'(prev_last));
      end
    end
    if (dout_valid) chk("flag_low_while_drain", 64'(output_buffer_available), 64'd0);
    if (output_buffer_we && dout_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL write_during_drain: output_buffer_we=1 while dout_valid=1");
    end
    if (dout_valid && dout_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %h, expected no word", dout);
      end else begin
        e = sb.pop_front();
        chk("dout_word", dout, e.d);
        chk("dout_last", 64'(dout_last), 64'(e.last));
        pop_cnt++;
        if (e.blk_end) chk_empty = 1'b1;
      end
    end
    prev_stall = dout_valid && !dout_ready;
    prev_dout  = dout;
    prev_last  = dout_last;
    prev_rst   = rst;
  end

  // Issue one block once the buffer is free; nwords is the hand-computed word count.
  task automatic write_block(input logic [1343:0] data, input logic [1:0] mode,
                             input logic [31:0] size, input logic last, input int nwords);
    int w;
    exp_t e;
    w = 0;
    while (!output_buffer_available && w < 5000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("write_wait", 64'(output_buffer_available), 64'd1);
    for (int i = 0; i < nwords; i++) begin
      e.d       = data[i*64 +: 64];
      e.last    = last && (i == nwords - 1);
      e.blk_end = (i == nwords - 1);
      sb.push_back(e);
    end
    rate_input                  = data;
    operation_mode_in           = mode;
    output_size_in              = size;
    last_output_block_wr        = last;
    output_buffer_we            = 1'b1;
    output_buffer_available_clr = 1'b1;
    @(posedge clk); #1;
    output_buffer_we            = 1'b0;
    output_buffer_available_clr = 1'b0;
    last_output_block_wr        = 1'b0;
    if (nwords > 0) chk("first_word_latency", 64'(dout_valid), 64'd1);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || !output_buffer_available) && w < 5000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_complete", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int w;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 64'd0);
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_last", 64'(dout_last), 64'd0);
    chk("rst_flag", 64'(output_buffer_available), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // SHAKE128, 256 bits: 4 words, last on word 3
    write_block(rand_block(), 2'd0, 32'd256, 1'b1, 4);
    wait_drain();

    // SHAKE128 multi-block 4096 bits: 21+21+21+1 words
    write_block(rand_block(), 2'd0, 32'd4096, 1'b0, 21);
    write_block(rand_block(), 2'd0, 32'd2752, 1'b0, 21);
    write_block(rand_block(), 2'd0, 32'd1408, 1'b0, 21);
    write_block(rand_block(), 2'd0, 32'd64,   1'b1, 1);
    wait_drain();

    // SHAKE256: partial word (size 100 -> 2 words), then rate-capped 2000 -> 17
    write_block(rand_block(), 2'd1, 32'd100,  1'b1, 2);
    write_block(rand_block(), 2'd1, 32'd2000, 1'b1, 17);
    wait_drain();

    // Largest size must not overflow: capped at 21 words
    write_block(rand_block(), 2'd0, 32'hFFFF_FFFF, 1'b0, 21);
    wait_drain();

    // Backpressure with random ready
    ready_mode = 2;
    write_block(rand_block(), 2'd0, 32'd1344, 1'b1, 21);
    wait_drain();
    ready_mode = 1;
    @(posedge clk); #1;

    // Reset after 5 of 21 words
    pop_cnt = 0;
    write_block(rand_block(), 2'd0, 32'd1344, 1'b1, 21);
    w = 0;
    while (pop_cnt < 5 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("reset_point_reached", 64'(pop_cnt), 64'd5);
    rst = 1'b1;
    ready_mode = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("midrst_valid", 64'(dout_valid), 64'd0);
    chk("midrst_flag", 64'(output_buffer_available), 64'd1);
    chk("midrst_dout", dout, 64'd0);
    chk("midrst_last", 64'(dout_last), 64'd0);
    ready_mode = 1;
    write_block(rand_block(), 2'd0, 32'd512, 1'b1, 8);
    wait_drain();

    // Zero-size write: no words, flag low for one cycle
    write_block(rand_block(), 2'd0, 32'd0, 1'b1, 0);
    chk("zero_valid_0", 64'(dout_valid), 64'd0);
    chk("zero_flag_0", 64'(output_buffer_available), 64'd0);
    @(posedge clk); #1;
    chk("zero_valid_1", 64'(dout_valid), 64'd0);
    chk("zero_flag_1", 64'(output_buffer_available), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("zero_no_words", 64'(dout_valid), 64'd0);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
